// File: rtl/full_adder_reg_pkg.sv
// Shared types and helpers for the registered ripple-carry adder.
package full_adder_reg_pkg;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_t;

    // Single-bit half adder; each full-adder cell uses two of these.
    function automatic ha_t half_add(input logic x, input logic y);
        ha_t r;
        r.sum   = x ^ y;
        r.carry = x & y;
        return r;
    endfunction

endpackage

// File: rtl/full_adder_reg_fa_cell.sv
// One-bit combinational full adder: two half adders plus an OR on their carries.
module full_adder_reg_fa_cell
    import full_adder_reg_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum_c,
    output logic c_out_c
);

    ha_t ha1;
    ha_t ha2;

    always_comb begin
        ha1 = half_add(a, b);
        ha2 = half_add(c_in, ha1.sum);
    end

    assign sum_c   = ha2.sum;
    assign c_out_c = ha1.carry | ha2.carry;

endmodule

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {c_out, sum} = a + b + c_in, one cycle after valid_in.
module full_adder_reg
    import full_adder_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             valid_out
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    assign carry[0] = c_in;

    // Carry chain: cell i consumes carry[i] and produces carry[i+1].
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        full_adder_reg_fa_cell u_cell (
            .a       (a[i]),
            .b       (b[i]),
            .c_in    (carry[i]),
            .sum_c   (sum_c[i]),
            .c_out_c (carry[i+1])
        );
    end

    // Result registers only load on a qualified cycle, so junk inputs never reach them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            c_out     <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                sum   <= sum_c;
                c_out <= carry[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder_reg.sv
// Randomized and directed checks of full_adder_reg at widths 1, 8 and 16.
module tb_full_adder_reg;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a1, b1, ci1, vi1, s1, co1, vo1;
    logic [7:0]  a8, b8, s8;
    logic        ci8, vi8, co8, vo8;
    logic [15:0] a16, b16, s16;
    logic        ci16, vi16, co16, vo16;

    int passed = 0;
    int total  = 0;

    full_adder_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(ci1), .valid_in(vi1),
        .sum(s1), .c_out(co1), .valid_out(vo1)
    );
    full_adder_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(ci8), .valid_in(vi8),
        .sum(s8), .c_out(co8), .valid_out(vo8)
    );
    full_adder_reg #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c_in(ci16), .valid_in(vi16),
        .sum(s16), .c_out(co16), .valid_out(vo16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic a, input logic b, input logic c, input logic v);
        @(negedge clk);
        a1 = a; b1 = b; ci1 = c; vi1 = v;
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        @(negedge clk);
        a8 = a; b8 = b; ci8 = c; vi8 = v;
    endtask

    // Reference: plain integer addition, widened so the carry is kept.
    function automatic logic [63:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
        return a + b + 64'(c);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  t;
        logic [63:0] e;
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic        vc [4];
        logic [15:0] ra, rb;
        logic        rc, rv;
        logic [16:0] exp16;
        logic        expv16;

        a1 = 0; b1 = 0; ci1 = 0; vi1 = 0;
        a8 = 0; b8 = 0; ci8 = 0; vi8 = 0;
        a16 = 0; b16 = 0; ci16 = 0; vi16 = 0;

        #2 rst_n = 1'b0;
        #1;
        check("reset_w1", 64'({co1, s1, vo1}), 64'd0);
        check("reset_w8", 64'({co8, s8, vo8}), 64'd0);
        check("reset_w16", 64'({co16, s16, vo16}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 1-bit truth table
        for (int i = 0; i < 8; i++) begin
            t = 3'(i);
            drive1(t[2], t[1], t[0], 1'b1);
            tick();
            e = ref_add(64'(t[2]), 64'(t[1]), t[0]);
            check($sformatf("tt_%0d", i), 64'({co1, s1}), e);
            check($sformatf("tt_valid_%0d", i), 64'(vo1), 64'd1);
        end

        // Asynchronous reset mid-stream
        drive1(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("pre_reset", 64'({co1, s1}), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 64'({co1, s1, vo1}), 64'd0);
        vi1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("post_reset", 64'({co1, s1, vo1}), 64'b011);

        // Hold with valid_in low, including unknown inputs
        drive1(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("hold_capture", 64'({co1, s1}), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive1(1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            check($sformatf("hold_%0d", i), 64'({co1, s1, vo1}), 64'b010);
        end
        drive1(1'bx, 1'bx, 1'bx, 1'b0);
        tick();
        check("hold_x", 64'({co1, s1, vo1}), 64'b010);

        // 8-bit carry chain boundaries
        drive8(8'hFF, 8'h00, 1'b1, 1'b1);
        tick();
        check("chain_ff", 64'({co8, s8}), 64'h100);
        drive8(8'h7F, 8'h01, 1'b0, 1'b1);
        tick();
        check("chain_7f", 64'({co8, s8}), 64'h080);

        // Back-to-back stream, one result per cycle
        va = '{8'd1, 8'd3, 8'd255, 8'd0};
        vb = '{8'd2, 8'd4, 8'd255, 8'd0};
        vc = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive8(va[i], vb[i], vc[i], 1'b1);
            tick();
            e = ref_add(64'(va[i]), 64'(vb[i]), vc[i]);
            check($sformatf("b2b_%0d", i), 64'({co8, s8}), e);
            check($sformatf("b2b_valid_%0d", i), 64'(vo8), 64'd1);
        end
        drive8(8'h55, 8'hAA, 1'b1, 1'b0);
        tick();
        check("b2b_idle", 64'({co8, s8, vo8}), 64'd0);

        // Randomized 16-bit compare against the arithmetic model
        exp16  = '0;
        expv16 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rv = ($urandom_range(3) != 0);
            @(negedge clk);
            if (!rv && ($urandom_range(7) == 0)) begin
                a16 = 'x; b16 = 'x; ci16 = 1'bx;
            end else begin
                a16 = ra; b16 = rb; ci16 = rc;
            end
            vi16 = rv;
            tick();
            if (rv) exp16 = 17'(ref_add(64'(ra), 64'(rb), rc));
            expv16 = rv;
            check($sformatf("rand_%0d", i), 64'({co16, s16, vo16}), 64'({exp16, expv16}));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Registered ripple-carry full adder: a + b + c_in, with sum and carry-out captured on the clock edge.
- Default WIDTH=1 gives the classic 1-bit full adder, built as two half adders plus an OR.
- Used as the arithmetic leaf cell for the datapath exercises.
- Adds a valid qualifier so downstream logic knows when outputs are meaningful.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sum  output  WIDTH  registered sum bits of a + b + c_in.
- c_out  output  1  registered carry-out of the MSB cell.
- valid_out  output  1  high for one cycle when sum/c_out hold a new result.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry into the LSB cell.
- valid_in  input  1  qualifies a/b/c_in for capture this cycle.

Behaviour:
- Reset:
  - rst_n low asynchronously forces sum=0, c_out=0, valid_out=0, regardless of clk.
  - Release is synchronised by the next rising edge.
- Combinational core: WIDTH chained full-adder cells; cell i takes a[i], b[i] and carry[i], with carry[0]=c_in.
  - Each cell: half adder 1 on (a, b); half adder 2 on (carry_in, ha1_sum).
  - Cell sum = ha2_sum; cell carry = ha1_carry OR ha2_carry.
  - Result: {c_out, sum} = a + b + c_in, exact, with no overflow loss (WIDTH+1 result bits).
- Latency: exactly 1 cycle.
  - On a rising edge with valid_in=1, the result is captured and valid_out=1 in the following cycle.
- Hold: on a rising edge with valid_in=0, sum/c_out keep their previous values and valid_out=0.
- Back-to-back: valid_in high on consecutive cycles produces one result per cycle, with no bubbles.
- Wrap-around, e.g. WIDTH=1 with a=b=c_in=1: sum=1, c_out=1. All-ones + all-ones + 1 gives sum all-ones and c_out=1.
- Reset mid-operation: any in-flight result is discarded; outputs read 0 until the next valid capture after release.
- X/Z on inputs while valid_in=0 must not corrupt the held outputs.
- No internal state beyond the output registers and valid_out.

Decomposition:
- Shared package: none required; WIDTH is the only constant.
- One natural sub-module, fa_cell: 1-bit combinational full adder (sum, c_out, a, b, c_in), itself built from two half-adder instances and an OR.
- Top level generates WIDTH fa_cell instances and the output registers.

Test Plan:
- Exhaustive 1-bit truth table. With WIDTH=1 and valid_in=1, apply (a,b,c_in) = 000,001,010,011,100,101,110,111, holding each for 20 ns.
  - Expected (sum,c_out) one cycle later: 00,10,10,01,10,01,01,11.
- Reset: assert rst_n=0 mid-stream after a=b=c_in=1 was captured.
  - sum=0, c_out=0, valid_out=0 immediately, without waiting for clk.
  - After release and one valid capture of 0,1,0: sum=1, c_out=0.
- Hold: capture a=1,b=0,c_in=0 (sum=1), then drive valid_in=0 with a=b=c_in=1 for 3 cycles.
  - sum stays 1, c_out stays 0, valid_out=0.
- Multi-bit carry chain. With WIDTH=8:
  - a=8'hFF, b=8'h00, c_in=1 -> sum=8'h00, c_out=1.
  - a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0.
- Back-to-back throughput: with WIDTH=8, stream 4 consecutive valid vectors (1+2+0, 3+4+1, 255+255+1, 0+0+0).
  - Results 3, 8, {1,8'hFF}, 0 appear on 4 consecutive cycles with valid_out=1.
- Randomized compare (WIDTH=16, 1000 vectors): {c_out,sum} equals a+b+c_in one cycle after each valid_in.
